// File: rtl/rr_mux_arbiter_pkg.sv
// mux_arb_pkg: shared constants, state encoding and rotating-priority helper for rr_mux_arbiter.
package mux_arb_pkg;

    localparam int NREQ = 4;
    localparam int SELW = 2;

    typedef enum logic {IDLE, GRANT} state_t;

    // Returns {found, idx}: first requester after last, wrapping so last itself is checked last.
    function automatic logic [SELW:0] rr_next(input logic [NREQ-1:0] req, input logic [SELW-1:0] last);
        logic [SELW-1:0] idx;
        rr_next = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = last + SELW'(k);
            if (req[idx]) rr_next = {1'b1, idx};
        end
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: producer request/data bundle plus the valid/ready output channel.
interface rr_mux_arbiter_if #(parameter int WIDTH = 8);
    import mux_arb_pkg::*;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] in;
    logic [NREQ-1:0]       ack;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out;
    logic [SELW-1:0]       sel;
    logic                  busy;

    modport master (
        input  req, in, out_ready,
        output ack, out_valid, out, sel, busy
    );

    modport slave (
        output req, in, out_ready,
        input  ack, out_valid, out, sel, busy
    );

endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// rr_pick: combinational rotating priority encoder; the previous holder has lowest priority.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0] i_req,
    input  logic [SELW-1:0] i_last,
    output logic [SELW-1:0] o_gnt_idx,
    output logic            o_any
);

    assign {o_any, o_gnt_idx} = rr_next(i_req, i_last);

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin burst arbiter sharing one WIDTH-bit valid/ready channel among 4 producers.
module rr_mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_mux_arbiter_if.master     bus
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    state_t          r_state, w_state_n;
    logic [SELW-1:0] r_sel, w_sel_n;
    logic [SELW-1:0] r_last, w_last_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;

    logic            w_valid, w_xfer, w_release, w_any;
    logic [SELW-1:0] w_pick_last, w_gnt_idx;

    assign w_valid   = (r_state == GRANT) && bus.req[r_sel];
    assign w_xfer    = w_valid && bus.out_ready;
    assign w_release = (r_state == GRANT) && (!bus.req[r_sel] || (w_xfer && r_cnt == CW'(MAX_BURST - 1)));

    // On release the current holder becomes "last", so rotate relative to it directly.
    assign w_pick_last = (r_state == GRANT) ? r_sel : r_last;

    rr_pick u_pick (
        .i_req     (bus.req),
        .i_last    (w_pick_last),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_last  <= SELW'(NREQ - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_sel   <= w_sel_n;
            r_last  <= w_last_n;
            r_cnt   <= w_cnt_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_sel_n   = r_sel;
        w_last_n  = r_last;
        w_cnt_n   = r_cnt;
        if (r_state == IDLE) begin
            if (w_any) begin
                w_state_n = GRANT;
                w_sel_n   = w_gnt_idx;
                w_cnt_n   = '0;
            end
        end else if (w_release) begin
            w_last_n = r_sel;
            w_state_n = w_any ? GRANT : IDLE;
            w_sel_n   = w_any ? w_gnt_idx : r_sel;
            w_cnt_n   = '0;
        end else if (w_xfer) begin
            w_cnt_n = r_cnt + CW'(1);
        end
    end

    assign bus.out_valid = w_valid;
    assign bus.ack       = {NREQ{w_xfer}} & (NREQ'(1) << r_sel);
    assign bus.out       = bus.in[r_sel*WIDTH +: WIDTH];
    assign bus.sel       = r_sel;
    assign bus.busy      = (r_state == GRANT);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed phases plus random traffic, scored against a transfer-counting burst model.
module tb_rr_mux_arbiter;
  localparam int WIDTH = 8;
  localparam int MB = 4;
  typedef struct packed {
    logic [3:0] ack;
    logic v;
    logic [WIDTH-1:0] o;
    logic [1:0] s;
    logic b;
  } exp_t;
  logic clk = 0;
  logic rst;
  always #5 clk = ~clk;
  rr_mux_arbiter_if #(.WIDTH(WIDTH)) bus ();
  rr_mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MB)) dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  logic busy_m;
  int owner, last, done;
  function automatic int pick(logic [3:0] r, int from);
    for (int i = 1; i <= 4; i++)
      if (r[(from + i) % 4]) return (from + i) % 4;
    return from;
  endfunction
  task automatic model_reset();
    busy_m = 0;
    owner = 0;
    last = 3;
    done = 0;
  endtask
  task automatic model_edge(logic [3:0] r, logic rdy);
    if (!busy_m) begin
      if (r != 0) begin
        busy_m = 1;
        owner = pick(r, last);
        done = 0;
      end
    end else begin
      if (r[owner] && rdy) done++;
      if (!r[owner] || done == MB) begin
        last = owner;
        if (r != 0) begin
          owner = pick(r, owner);
          done = 0;
        end else busy_m = 0;
      end
    end
  endtask
  task automatic step(logic r_rst, logic [3:0] r_req, logic rdy, logic [31:0] data);
    exp_t e;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(bus.req, bus.out_ready);
    #1;
    rst = r_rst;
    bus.req = r_req;
    bus.out_ready = rdy;
    bus.in = data;
    if (r_rst) model_reset();
    e.b = busy_m;
    e.v = busy_m && r_req[owner];
    e.ack = (e.v && rdy) ? (4'b0001 << owner) : 4'b0000;
    e.o = data[owner*WIDTH +: WIDTH];
    e.s = 2'(owner);
    q.push_back(e);
  endtask
  initial begin : monitor
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{ack: bus.ack, v: bus.out_valid, o: bus.out, s: bus.sel, b: bus.busy};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle_out @%0t: got ack=%b v=%b out=%h sel=%0d busy=%b, want ack=%b v=%b out=%h sel=%0d busy=%b",
                   $time, a.ack, a.v, a.o, a.s, a.b, e.ack, e.v, e.o, e.s, e.b);
        end
      end
    end
  end
  initial begin
    rst = 1;
    bus.req = '0;
    bus.in = '0;
    bus.out_ready = 0;
    model_reset();
    for (int i = 0; i < 3; i++) step(1, 4'b1111, 1, $urandom);
    @(negedge clk);
    #1;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.ack !== 4'b0000 || bus.sel !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state @%0t: busy=%b out_valid=%b ack=%b sel=%0d", $time, bus.busy, bus.out_valid, bus.ack, bus.sel);
    end
    for (int i = 0; i < 20; i++) step(0, 4'b1111, 1, $urandom);
    for (int i = 0; i < 3; i++) step(0, 4'b0000, 1, $urandom);
    for (int i = 0; i < 14; i++) step(0, 4'b0100, 1, {8'h00, 8'hA5, 8'h00, 8'h00} | ($urandom & 32'hFF00FFFF));
    for (int i = 0; i < 3; i++) step(0, 4'b0000, 1, $urandom);
    for (int i = 0; i < 12; i++) step(0, 4'b0010, 0, $urandom);
    for (int i = 0; i < 4; i++) step(0, 4'b0010, 1, $urandom);
    for (int i = 0; i < 3; i++) step(0, 4'b0000, 1, $urandom);
    for (int i = 0; i < 3; i++) step(0, 4'b1001, 1, $urandom);
    for (int i = 0; i < 7; i++) step(0, 4'b1000, 1, $urandom);
    for (int i = 0; i < 4; i++) step(0, 4'b0100, 1, $urandom);
    step(1, 4'b0100, 1, $urandom);
    step(0, 4'b1111, 1, $urandom);
    for (int i = 0; i < 6; i++) step(0, 4'b1111, 1, $urandom);
    for (int i = 0; i < 2000; i++)
      step(($urandom_range(0, 199) == 0), 4'($urandom), ($urandom_range(0, 9) < 7), $urandom);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL wait_expired @%0t: %0d expected vectors never checked", $time, q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
